// File: rtl/sram_mem_ctrl.sv
// Multi-cycle data-memory controller for the MEM stage: splits one DATA_W access into
// BEATS little-endian SRAM beats of WAIT_CYCLES clocks each, stalling the pipeline via ready.
module sram_mem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int SRAM_DATA_W = 16,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 5,
    parameter int BASE_ADDR   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [DATA_W-1:0]      write_data,
    output logic [DATA_W-1:0]      read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_we_n
);
    localparam int BEATS   = DATA_W / SRAM_DATA_W;
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int BEAT_SH = $clog2(BEATS);
    localparam int IDX_W   = SRAM_ADDR_W - BEAT_SH;
    localparam int BCW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WCW     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [WCW-1:0] LAST_WAIT = WCW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_nxt;
    logic              op_wr;
    logic [IDX_W-1:0]  word_idx;
    logic [DATA_W-1:0] wdata, rd_buf, rd_merge;
    logic [BCW-1:0]    beat;
    logic [WCW-1:0]    wait_cnt;
    logic [31:0]       addr_off;
    logic              req, beat_end, last_beat;

    assign req       = wr_en | rd_en;
    assign addr_off  = address - 32'(BASE_ADDR);
    assign beat_end  = (wait_cnt == LAST_WAIT);
    assign last_beat = beat_end && (beat == LAST_BEAT);

    // Read word being assembled; read_data itself only changes when the last beat lands.
    always_comb begin
        rd_merge = rd_buf;
        rd_merge[beat*SRAM_DATA_W +: SRAM_DATA_W] = sram_dq_in;
    end

    always_comb begin
        state_nxt   = state;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            IDLE: begin
                ready = ~req;
                if (req) state_nxt = ACCESS;
            end
            ACCESS: begin
                sram_addr = SRAM_ADDR_W'(word_idx) * SRAM_ADDR_W'(BEATS) + SRAM_ADDR_W'(beat);
                if (op_wr) begin
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                    sram_dq_out = wdata[beat*SRAM_DATA_W +: SRAM_DATA_W];
                end
                if (last_beat) state_nxt = DONE;
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            op_wr     <= 1'b0;
            word_idx  <= '0;
            wdata     <= '0;
            rd_buf    <= '0;
            read_data <= '0;
            beat      <= '0;
            wait_cnt  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr    <= wr_en;  // write wins when both are requested
                        word_idx <= IDX_W'(addr_off >> BYTE_SH);
                        wdata    <= write_data;
                        beat     <= '0;
                        wait_cnt <= '0;
                    end
                end
                ACCESS: begin
                    if (beat_end) begin
                        wait_cnt <= '0;
                        beat     <= last_beat ? '0 : beat + 1'b1;
                        if (!op_wr) begin
                            rd_buf <= rd_merge;
                            if (last_beat) read_data <= rd_merge;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Randomized bench for sram_mem_ctrl: transaction-level timeline model plus a pin-level SRAM,
// with a second narrow, single-wait instance exercised directly.
module tb_sram_mem_ctrl;
    localparam int DW = 32, SW = 16, AW = 18, WC = 5, BASE = 1024;
    localparam int B = DW / SW, N = B * WC;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          wr_en, rd_en;
    logic [31:0]   address;
    logic [DW-1:0] write_data, read_data;
    logic          ready, sram_dq_oe, sram_we_n;
    logic [AW-1:0] sram_addr;
    logic [SW-1:0] sram_dq_out, sram_dq_in;

    sram_mem_ctrl #(.DATA_W(DW), .SRAM_DATA_W(SW), .SRAM_ADDR_W(AW),
                    .WAIT_CYCLES(WC), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n));

    // Narrow instance: one beat, one wait state; its SRAM is a ROM keyed on address.
    logic          b_wr, b_rd, b_ready, b_oe, b_we_n;
    logic [31:0]   b_addr;
    logic [15:0]   b_wdata, b_rdata, b_dq_out, b_dq_in;
    logic [AW-1:0] b_sram_addr;

    sram_mem_ctrl #(.DATA_W(16), .SRAM_DATA_W(16), .SRAM_ADDR_W(AW),
                    .WAIT_CYCLES(1), .BASE_ADDR(BASE)) dut_b (
        .clk(clk), .rst(rst), .wr_en(b_wr), .rd_en(b_rd), .address(b_addr),
        .write_data(b_wdata), .read_data(b_rdata), .ready(b_ready),
        .sram_addr(b_sram_addr), .sram_dq_out(b_dq_out), .sram_dq_oe(b_oe),
        .sram_dq_in(b_dq_in), .sram_we_n(b_we_n));
    assign b_dq_in = b_sram_addr[15:0] ^ 16'hA5A5;

    // Pin-level SRAM driven by the DUT, and the reference image kept by the model.
    logic [SW-1:0] sram    [0:(1<<AW)-1];
    logic [SW-1:0] ref_mem [0:(1<<AW)-1];
    assign sram_dq_in = sram[sram_addr];
    always @(posedge clk) if (sram_we_n === 1'b0) sram[sram_addr] = sram_dq_out;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: m_k counts cycles since the request (0 = request, 1..N = access, N+1 = done).
    bit            m_busy = 1'b0;
    int            m_k = 0;
    bit            m_wr = 1'b0;
    int unsigned   m_idx = 0;
    logic [DW-1:0] m_data = '0, m_rdata = '0;
    int            run_len = 0, last_run = 0;

    always @(negedge clk) begin
        int bt;
        logic [AW-1:0] e_addr;
        logic [SW-1:0] e_dq;
        if (!rst) begin
            chk("rst_ready", ready, !(wr_en || rd_en));
            chk("rst_we_n", sram_we_n, 1'b1);
            chk("rst_oe", sram_dq_oe, 1'b0);
            chk("rst_addr", sram_addr, 0);
            chk("rst_dq_out", sram_dq_out, 0);
            chk("rst_rdata", read_data, 0);
        end else if (!m_busy) begin
            chk("idle_ready", ready, !(wr_en || rd_en));
            chk("idle_we_n", sram_we_n, 1'b1);
            chk("idle_oe", sram_dq_oe, 1'b0);
            chk("idle_rdata", read_data, m_rdata);
        end else if (m_k == 0) begin
            chk("req_ready", ready, 1'b0);
            chk("req_we_n", sram_we_n, 1'b1);
            chk("req_oe", sram_dq_oe, 1'b0);
        end else if (m_k <= N) begin
            bt     = (m_k - 1) / WC;
            e_addr = AW'(m_idx * B + bt);
            e_dq   = SW'(m_data >> (SW * bt));
            chk("acc_ready", ready, 1'b0);
            chk("acc_addr", sram_addr, e_addr);
            chk("acc_we_n", sram_we_n, !m_wr);
            chk("acc_oe", sram_dq_oe, m_wr);
            if (m_wr) chk("acc_dq_out", sram_dq_out, e_dq);
            chk("acc_rdata_hold", read_data, m_rdata);
        end else begin
            chk("done_ready", ready, 1'b1);
            chk("done_we_n", sram_we_n, 1'b1);
            chk("done_oe", sram_dq_oe, 1'b0);
            chk("done_rdata", read_data, m_rdata);
        end
        if (ready === 1'b0) run_len++;
        else begin
            if (run_len > 0) last_run = run_len;
            run_len = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_model(input bit wr, input logic [31:0] a, input logic [DW-1:0] d);
        m_busy = 1'b1;
        m_k    = 0;
        m_wr   = wr;
        m_idx  = ((a - 32'(BASE)) >> 2) & 32'((1 << (AW - 1)) - 1);
        m_data = d;
    endtask

    // One pipeline access; with junk set the inputs wander while the controller is busy.
    task automatic do_req(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [DW-1:0] d, input bit junk);
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        if (!(wr || rd)) begin
            m_busy = 1'b0;
            tick();
            return;
        end
        start_model(wr, a, d);
        for (int k = 1; k <= N + 1; k++) begin
            tick();
            m_k = k;
            if (junk) begin
                wr_en = 1'($urandom_range(0, 1));
                rd_en = 1'($urandom_range(0, 1));
                address = $urandom;
                write_data = DW'($urandom);
            end else begin
                wr_en = 1'b0; rd_en = 1'b0;
            end
            if (k == N + 1) begin
                for (int b = 0; b < B; b++) begin
                    if (wr) ref_mem[(m_idx * B + b) % (1 << AW)] = d[b*SW +: SW];
                    else m_rdata[b*SW +: SW] = ref_mem[(m_idx * B + b) % (1 << AW)];
                end
            end
        end
        tick();
        m_busy = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        b_wr = 1'b0; b_rd = 1'b0; b_addr = '0; b_wdata = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i]    = SW'($urandom);
            ref_mem[i] = sram[i];
        end
        tick(); tick();
        chk("reset_ready_lit", ready, 1'b1);
        chk("reset_we_n_lit", sram_we_n, 1'b1);
        rst = 1'b1;
        tick();

        do_req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
        chk("wr_low_cycles", last_run, 11);
        chk("wr_beat0_mem", sram[0], 16'hBEEF);
        chk("wr_beat1_mem", sram[1], 16'hDEAD);

        do_req(1'b0, 1'b1, 32'd1024, '0, 1'b0);
        chk("rd_word_lit", read_data, 32'hDEADBEEF);
        chk("rd_low_cycles", last_run, 11);

        do_req(1'b1, 1'b1, 32'd1028, 32'h12345678, 1'b1);
        chk("both_mem2", sram[2], 16'h5678);
        chk("both_mem3", sram[3], 16'h1234);
        chk("both_no_capture", read_data, 32'hDEADBEEF);

        do_req(1'b1, 1'b0, 32'd0, 32'h0BADCAFE, 1'b0);
        chk("wrap_lo", sram[18'h3FE00], 16'hCAFE);
        chk("wrap_hi", sram[18'h3FE01], 16'h0BAD);

        do_req(1'b0, 1'b0, 32'd1024, '0, 1'b0);
        do_req(1'b0, 1'b0, 32'd2048, '0, 1'b0);

        // Abort a write during its second beat.
        wr_en = 1'b1; address = 32'd2048; write_data = 32'hCAFEF00D;
        start_model(1'b1, 32'd2048, 32'hCAFEF00D);
        for (int k = 1; k <= 7; k++) begin
            tick();
            m_k = k;
            wr_en = 1'b0;
        end
        #2;
        rst = 1'b0; m_busy = 1'b0; m_rdata = '0;
        #1;
        chk("abort_we_n", sram_we_n, 1'b1);
        chk("abort_oe", sram_dq_oe, 1'b0);
        chk("abort_addr", sram_addr, 0);
        chk("abort_ready", ready, 1'b1);
        chk("abort_rdata", read_data, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        do_req(1'b1, 1'b0, 32'd2048, 32'h600DD00D, 1'b0);
        chk("post_abort_low_cycles", last_run, 11);
        do_req(1'b0, 1'b1, 32'd2048, '0, 1'b0);
        chk("post_abort_rd_lit", read_data, 32'h600DD00D);

        for (int t = 0; t < 48; t++) begin
            int op;
            logic [31:0] a;
            op = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = 32'(BASE) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            do_req(op == 1 || op == 3, op == 2 || op == 3, a, DW'($urandom),
                   1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 16; i++)
            do_req(1'b0, 1'b1, 32'(BASE + 4 * i), '0, 1'($urandom_range(0, 1)));

        // Narrow instance: two back-to-back reads, two cycles low each.
        b_rd = 1'b1; b_addr = 32'd1034;
        #3 chk("b_req1_ready", b_ready, 1'b0);
        tick(); b_rd = 1'b0;
        #3 chk("b_acc1_ready", b_ready, 1'b0);
        chk("b_acc1_addr", b_sram_addr, 5);
        chk("b_acc1_oe", b_oe, 1'b0);
        tick();
        #3 chk("b_done1_ready", b_ready, 1'b1);
        chk("b_done1_rdata", b_rdata, 16'hA5A0);
        tick(); b_rd = 1'b1; b_addr = 32'd1042;
        #3 chk("b_req2_ready", b_ready, 1'b0);
        tick(); b_rd = 1'b0;
        #3 chk("b_acc2_ready", b_ready, 1'b0);
        chk("b_acc2_addr", b_sram_addr, 9);
        tick();
        #3 chk("b_done2_ready", b_ready, 1'b1);
        chk("b_done2_rdata", b_rdata, 16'hA5AC);
        tick();
        #3 chk("b_idle_ready", b_ready, 1'b1);
        chk("b_idle_rdata", b_rdata, 16'hA5AC);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
Parametrised multi-cycle memory controller that replaces the single-cycle data memory in the MEM stage of the ARM pipeline.
- Converts one pipeline word access (read or write) into BEATS narrower external SRAM accesses, each held for WAIT_CYCLES clocks.
- Drives `ready` low while busy so the hazard/freeze logic stalls every pipeline register.
- Supersedes the fixed-width, zero-latency data memory with configurable data width, SRAM width, wait states and base address.

Parameters:
- DATA_W, 32, pipeline data word width; must be an integer multiple of SRAM_DATA_W.
- SRAM_DATA_W, 16, external SRAM data bus width.
- SRAM_ADDR_W, 18, external SRAM address width.
- WAIT_CYCLES, 5, clocks each SRAM beat is held; must be ≥ 1.
- BASE_ADDR, 1024, byte address mapped to SRAM beat address 0.
- Derived: BEATS = DATA_W/SRAM_DATA_W; BYTE_SH = log2(DATA_W/8).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- wr_en  in  1  write request from the MEM stage.
- rd_en  in  1  read request from the MEM stage.
- address  in  32  byte address (ALU result).
- write_data  in  DATA_W  store data (Rm value).
- read_data  out  DATA_W  load data; valid when ready=1 in DONE.
- ready  out  1  0 = busy, pipeline must freeze.
- sram_addr  out  SRAM_ADDR_W  SRAM beat address.
- sram_dq_out  out  SRAM_DATA_W  SRAM write data.
- sram_dq_oe  out  1  1 = controller drives the DQ bus.
- sram_dq_in  in  SRAM_DATA_W  SRAM read data.
- sram_we_n  out  1  SRAM write enable, active-low.

Behaviour:
Reset (rst=0, asynchronous):
- FSM to IDLE; beat and wait counters to 0; read_data=0.
- sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- ready=1 whenever the FSM is in IDLE with no request (including during reset).
- Reset mid-operation aborts the access immediately; a partial SRAM write is not completed.

FSM IDLE:
- ready = ~(wr_en | rd_en), combinational, so the stall is asserted in the same cycle the request appears.
- On a request: latch op, word index and write_data; go to ACCESS with beat=0, wait=0.
- If wr_en and rd_en are both high, the write wins.

FSM ACCESS:
- ready=0.
- Word index = (address − BASE_ADDR) >> BYTE_SH, computed modulo 2^32 and truncated to SRAM_ADDR_W − log2(BEATS) bits. Out-of-range addresses wrap silently.
- sram_addr = word_index*BEATS + beat.
- Beat order is little-endian: beat b carries data bits [(b+1)*SRAM_DATA_W−1 : b*SRAM_DATA_W].
- Write: sram_dq_oe=1, sram_we_n=0, sram_dq_out = latched slice for the current beat.
- Read: sram_dq_oe=0, sram_we_n=1; the read_data slice for beat b is captured from sram_dq_in on the last wait cycle of that beat (wait == WAIT_CYCLES−1).
- wait increments every cycle. On wait == WAIT_CYCLES−1: wait→0 and beat increments.
- After the last beat completes, go to DONE.
- Changes on inputs during ACCESS are ignored (inputs were latched).

FSM DONE (exactly 1 cycle):
- ready=1; read_data holds the assembled word; sram_we_n=1, sram_dq_oe=0.
- Next state is IDLE. The pipeline advances on this edge, so the following cycle sees the next instruction's request.

Latency:
- Request cycle in IDLE, then BEATS*WAIT_CYCLES cycles of ACCESS, then 1 cycle of DONE.
- ready is low for 1 + BEATS*WAIT_CYCLES consecutive cycles (defaults: 11), then high for 1.
- Back-to-back requests have no idle gap beyond the DONE cycle.

Other rules:
- read_data holds its value until the next read completes. Writes do not modify read_data.
- No request (wr_en=rd_en=0) costs 0 cycles, and ready stays 1.

Test Plan:
- Reset → ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0, sram_addr=0.
- Write 0xDEADBEEF to address 1024, defaults → ready=0 for 11 cycles; sram_addr=0 with dq_out=0xBEEF and we_n=0 for 5 cycles, then sram_addr=1 with dq_out=0xDEAD for 5 cycles; DONE on the 12th cycle.
- Read address 1024 with an SRAM model preloaded from the previous write → read_data=0xDEADBEEF when ready rises; dq_oe=0 throughout.
- Address 1028, wr_en=rd_en=1, data 0x12345678 → write performed at sram_addr 2 and 3 (0x5678, 0x1234); no read capture.
- rst pulsed low during beat 1 of a write → outputs return to reset values in the same cycle; the next request starts at beat 0 with full latency.
- Parameter override WAIT_CYCLES=1, DATA_W=SRAM_DATA_W=16 → ready low exactly 2 cycles per access; two back-to-back reads return correct words with one DONE cycle between them.
